// File: rtl/mem_ctrler_pkg.sv
// Shared types and constants for the byte-wide RAM port controller.
// Size encodings and the IO region tag match the LSU's view of memory.
package mem_ctrler_pkg;

  typedef logic [31:0]  addr_t;
  typedef logic [127:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE,
    INST_READ,
    DATA_READ,
    DATA_WRITE
  } state_e;

  typedef enum logic {
    CL_LSU,
    CL_INST
  } client_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;
  localparam logic [1:0] IO_ADDR_HI    = 2'b11;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    unique case (sz)
      MEM_SIZE_BYTE: n = 3'd1;
      MEM_SIZE_HALF: n = 3'd2;
      default:       n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrler.sv
// Byte-serial RAM port owner: arbitrates icache refills and LSU accesses.
// Define MEM_CTRLER_ROUND_ROBIN_EN for round-robin; default is LSU-first.
module mem_ctrler
  import mem_ctrler_pkg::*;
#(
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full,
  input  logic                    valid_from_inst_fetcher,
  input  logic [31:0]             addr_from_inst_fetcher,
  output logic                    ready_to_inst_fetcher,
  output logic [LINE_BYTES*8-1:0] cache_line_to_inst_fetcher,
  input  logic                    valid_from_lsu,
  input  logic                    is_write_from_lsu,
  input  logic [31:0]             addr_from_lsu,
  input  logic [1:0]              size_from_lsu,
  input  logic [31:0]             data_from_lsu,
  output logic                    ready_to_lsu,
  output logic [31:0]             data_to_lsu,
  input  logic                    reset_from_rob_bus
);

  localparam int    CW    = $clog2(LINE_BYTES) + 1;
  localparam int    LW    = LINE_BYTES * 8;
  localparam addr_t LMASK = addr_t'(LINE_BYTES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;
  addr_t         a_q, a_d;
  logic [7:0]    dout_q, dout_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [LW-1:0] line_q, line_d;
  logic          irdy_q, irdy_d;
  logic          drdy_q, drdy_d;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
  client_e       prio_q, prio_d;
`endif

  logic io_stall;
  logic lsu_ok;
  logic pick_lsu;
  logic pick_inst;
  logic last_beat;

  // Flushed loads are dropped at the door; stores still commit.
  assign io_stall = is_write_from_lsu && io_buffer_full
                 && addr_from_lsu[17:16] == IO_ADDR_HI;
  assign lsu_ok   = valid_from_lsu && !io_stall
                 && !(reset_from_rob_bus && !is_write_from_lsu);
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
  assign pick_lsu = lsu_ok
                 && (!valid_from_inst_fetcher || prio_q == CL_LSU);
`else
  assign pick_lsu = lsu_ok;
`endif
  assign pick_inst = valid_from_inst_fetcher && !pick_lsu;
  assign last_beat = cnt_q == last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      a_q     <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      line_q  <= '0;
      irdy_q  <= 1'b0;
      drdy_q  <= 1'b0;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
      prio_q  <= CL_LSU;
`endif
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      line_q  <= line_d;
      irdy_q  <= irdy_d;
      drdy_q  <= drdy_d;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_lsu)
          state_d = is_write_from_lsu ? DATA_WRITE : DATA_READ;
        else if (pick_inst)
          state_d = INST_READ;
      end
      DATA_READ: begin
        if (reset_from_rob_bus || last_beat)
          state_d = IDLE;
      end
      default: begin
        if (last_beat)
          state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    a_d     = a_q;
    dout_d  = dout_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    line_d  = line_q;
    irdy_d  = 1'b0;
    drdy_d  = 1'b0;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_lsu) begin
          a_d     = addr_from_lsu;
          last_d  = CW'(size_bytes(size_from_lsu) - 3'd1);
          wdata_d = data_from_lsu;
          rdata_d = '0;
          dout_d  = data_from_lsu[7:0];
          wr_d    = is_write_from_lsu;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
          prio_d  = CL_INST;
`endif
        end else if (pick_inst) begin
          a_d    = addr_from_inst_fetcher & ~LMASK;
          last_d = CW'(LINE_BYTES - 1);
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
          prio_d = CL_LSU;
`endif
        end
      end
      INST_READ: begin
        line_d[{cnt_q[CW-2:0], 3'b000} +: 8] = mem_din;
        if (last_beat) begin
          irdy_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          a_d   = a_q + 32'd1;
        end
      end
      DATA_READ: begin
        if (!reset_from_rob_bus) begin
          rdata_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
          if (last_beat) begin
            drdy_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            a_d   = a_q + 32'd1;
          end
        end
      end
      default: begin
        // Store data shifts down so the next byte is always [15:8].
        if (last_beat) begin
          drdy_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          a_d     = a_q + 32'd1;
          wr_d    = 1'b1;
          wdata_d = wdata_q >> 8;
          dout_d  = wdata_q[15:8];
        end
      end
    endcase
  end

  assign mem_a                      = a_q;
  assign mem_dout                   = dout_q;
  assign mem_wr                     = wr_q;
  assign ready_to_inst_fetcher      = irdy_q;
  assign cache_line_to_inst_fetcher = line_q;
  assign ready_to_lsu               = drdy_q;
  assign data_to_lsu                = rdata_q;

endmodule

// File: tb/tb_mem_ctrler.sv
// Randomised bench for mem_ctrler against a byte-array memory model.
// Arbitration expectations follow MEM_CTRLER_ROUND_ROBIN_EN.
module tb_mem_ctrler;

  localparam int LB  = 16;
  localparam int LW  = LB * 8;
  localparam int MSZ = 1 << 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;
  logic [31:0]   mem_a;
  logic          mem_wr;
  logic          io_buffer_full;
  logic          valid_from_inst_fetcher;
  logic [31:0]   addr_from_inst_fetcher;
  logic          ready_to_inst_fetcher;
  logic [LW-1:0] cache_line_to_inst_fetcher;
  logic          valid_from_lsu;
  logic          is_write_from_lsu;
  logic [31:0]   addr_from_lsu;
  logic [1:0]    size_from_lsu;
  logic [31:0]   data_from_lsu;
  logic          ready_to_lsu;
  logic [31:0]   data_to_lsu;
  logic          reset_from_rob_bus;

  always #5 clk = ~clk;

  mem_ctrler #(.LINE_BYTES(LB)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .rdy                        (rdy),
    .mem_din                    (mem_din),
    .mem_dout                   (mem_dout),
    .mem_a                      (mem_a),
    .mem_wr                     (mem_wr),
    .io_buffer_full             (io_buffer_full),
    .valid_from_inst_fetcher    (valid_from_inst_fetcher),
    .addr_from_inst_fetcher     (addr_from_inst_fetcher),
    .ready_to_inst_fetcher      (ready_to_inst_fetcher),
    .cache_line_to_inst_fetcher (cache_line_to_inst_fetcher),
    .valid_from_lsu             (valid_from_lsu),
    .is_write_from_lsu          (is_write_from_lsu),
    .addr_from_lsu              (addr_from_lsu),
    .size_from_lsu              (size_from_lsu),
    .data_from_lsu              (data_from_lsu),
    .ready_to_lsu               (ready_to_lsu),
    .data_to_lsu                (data_to_lsu),
    .reset_from_rob_bus         (reset_from_rob_bus)
  );

  logic [7:0] ram   [MSZ];
  logic [7:0] model [MSZ];

  assign mem_din = ram[mem_a[17:0]];
  always @(posedge clk) if (mem_wr) ram[mem_a[17:0]] <= mem_dout;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ix(input logic [31:0] a);
    return int'(a[17:0]);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input int nb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = model[ix(a + 32'(i))];
    return v;
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] a);
    logic [LW-1:0] v;
    logic [31:0]   b;
    b = a & ~32'(LB - 1);
    for (int k = 0; k < LB; k++) v[8*k +: 8] = model[ix(b + 32'(k))];
    return v;
  endfunction

  // lat = edges from accept-edge to ready edge, -1 if no ready.
  task automatic run_req(input bit inst, input bit w,
      input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
      input int flush_at, input int stall_at,
      output int lat, output logic [31:0] q, output logic [LW-1:0] ln,
      output logic [31:0] a0, output logic [31:0] ae);
    int          e;
    bit          got;
    logic [31:0] ma;
    e   = -1;
    got = 1'b0;
    a0  = 'x;
    valid_from_inst_fetcher = inst;
    addr_from_inst_fetcher  = a;
    valid_from_lsu          = !inst;
    is_write_from_lsu       = w;
    addr_from_lsu           = a;
    size_from_lsu           = sz;
    data_from_lsu           = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      e++;
      reset_from_rob_bus = 1'b0;
      if (inst ? ready_to_inst_fetcher : ready_to_lsu) begin
        got = 1'b1;
      end else begin
        if (e == 0) a0 = mem_a;
        if (e == flush_at) begin
          reset_from_rob_bus = 1'b1;
          if (!inst && !w) valid_from_lsu = 1'b0;
        end
        if (e == stall_at) begin
          rdy = 1'b0;
          ma  = mem_a;
          repeat (3) begin
            @(posedge clk); #1;
            e++;
            chk("stall_mem_a", mem_a, ma);
          end
          rdy = 1'b1;
        end
      end
    end
    lat = got ? e : -1;
    q   = data_to_lsu;
    ln  = cache_line_to_inst_fetcher;
    ae  = mem_a;
    valid_from_inst_fetcher = 1'b0;
    valid_from_lsu          = 1'b0;
    if (got) begin
      @(posedge clk); #1;
      chk("pulse_width", {ready_to_inst_fetcher, ready_to_lsu}, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0]   q, a0, ae, a, d;
    logic [LW-1:0] ln;
    logic [1:0]    sz;
    int            lat, bad, win, kind, nb;

    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    valid_from_inst_fetcher = 1'b0; addr_from_inst_fetcher = '0;
    valid_from_lsu = 1'b0; is_write_from_lsu = 1'b0;
    addr_from_lsu = '0; size_from_lsu = '0; data_from_lsu = '0;
    reset_from_rob_bus = 1'b0;
    for (int i = 0; i < MSZ; i++) begin
      ram[i]   = 8'($urandom);
      model[i] = ram[i];
    end
    for (int k = 0; k < LB; k++) begin
      ram[32'h1000 + k]   = 8'(k);
      model[32'h1000 + k] = 8'(k);
    end
    ram[32'h2002] = 8'hAA; ram[32'h2003] = 8'hBB;
    ram[32'h2004] = 8'hCC; ram[32'h2005] = 8'hDD;
    for (int k = 0; k < 4; k++) model[32'h2002 + k] = ram[32'h2002 + k];

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_ready", {ready_to_inst_fetcher, ready_to_lsu}, 0);
    chk("rst_data", data_to_lsu, 0);
    chk("rst_line", cache_line_to_inst_fetcher, 0);
    rst = 1'b0;

    // Both clients in the same cycle; loser withdraws each round.
    for (int r = 0; r < 4; r++) begin
      addr_from_inst_fetcher = 32'h1000;
      valid_from_inst_fetcher = 1'b1;
      addr_from_lsu = 32'h2002; is_write_from_lsu = 1'b0;
      size_from_lsu = 2'd2; valid_from_lsu = 1'b1;
      win = 2;
      for (int i = 0; i < 40 && win == 2; i++) begin
        @(posedge clk); #1;
        if (ready_to_lsu) win = 1;
        else if (ready_to_inst_fetcher) win = 0;
      end
      valid_from_inst_fetcher = 1'b0;
      valid_from_lsu = 1'b0;
      @(posedge clk); #1;
`ifdef MEM_CTRLER_ROUND_ROBIN_EN
      chk("arb_winner", win, (r % 2 == 0) ? 1 : 0);
`else
      chk("arb_winner", win, 1);
`endif
    end

    run_req(1, 0, 32'h1004, 0, 0, -1, -1, lat, q, ln, a0, ae);
    chk("refill_lat", lat, 16);
    chk("refill_base", a0, 32'h1000);
    chk("refill_last_a", ae, 32'h100F);
    chk("refill_line", ln, 128'h0f0e0d0c0b0a09080706050403020100);

    run_req(0, 0, 32'h2002, 2, 0, -1, -1, lat, q, ln, a0, ae);
    chk("ldw_lat", lat, 4);
    chk("ldw_data", q, 32'hDDCCBBAA);
    run_req(0, 0, 32'h2002, 1, 0, -1, -1, lat, q, ln, a0, ae);
    chk("ldh_lat", lat, 2);
    chk("ldh_data", q, 32'h0000BBAA);
    run_req(0, 0, 32'h2003, 0, 0, -1, -1, lat, q, ln, a0, ae);
    chk("ldb_data", q, 32'h000000BB);

    // IO store held off while the UART buffer is full.
    valid_from_lsu = 1'b1; is_write_from_lsu = 1'b1;
    addr_from_lsu = 32'h30000; size_from_lsu = 2'd0;
    data_from_lsu = 32'h41; io_buffer_full = 1'b1;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_wr) bad++;
    end
    chk("io_stall_wr", bad, 0);
    io_buffer_full = 1'b0;
    @(posedge clk); #1;
    chk("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'h41});
    @(posedge clk); #1;
    chk("io_ready", {ready_to_lsu, mem_wr}, 2'b10);
    valid_from_lsu = 1'b0;
    model[32'h30000] = 8'h41;
    @(posedge clk); #1;
    chk("io_ram", ram[32'h30000], 8'h41);

    run_req(0, 0, 32'h2002, 2, 0, 2, -1, lat, q, ln, a0, ae);
    chk("flush_load_nordy", lat, -1);
    chk("flush_load_idle", ae, 32'h2004);
    d = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) model[32'h2100 + i] = d[8*i +: 8];
    run_req(0, 1, 32'h2100, 2, d, 2, -1, lat, q, ln, a0, ae);
    chk("flush_store_lat", lat, 4);
    run_req(1, 0, 32'h2104, 0, 0, 5, -1, lat, q, ln, a0, ae);
    chk("flush_inst_lat", lat, 16);
    chk("flush_inst_line", ln, ref_line(32'h2104));
    reset_from_rob_bus = 1'b1;
    run_req(0, 0, 32'h2100, 2, 0, -1, -1, lat, q, ln, a0, ae);
    chk("flush_at_req_lat", lat, 5);
    chk("flush_at_req_data", q, 32'hCAFEF00D);

    run_req(1, 0, 32'h1008, 0, 0, -1, 5, lat, q, ln, a0, ae);
    chk("stall_lat", lat, 19);
    chk("stall_line", ln, 128'h0f0e0d0c0b0a09080706050403020100);

    valid_from_lsu = 1'b1; is_write_from_lsu = 1'b0;
    addr_from_lsu = 32'h2002; size_from_lsu = 2'd2;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    valid_from_lsu = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_out", {mem_wr, ready_to_lsu, data_to_lsu, mem_a}, 0);
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ready_to_lsu || ready_to_inst_fetcher) bad++;
    end
    chk("rst_mid_nordy", bad, 0);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = 32'($urandom_range(0, 32'h3FFF));
      sz   = 2'($urandom_range(0, 2));
      d    = $urandom;
      nb   = 1 << sz;
      if (kind == 0) begin
        run_req(1, 0, a, 0, 0, -1, -1, lat, q, ln, a0, ae);
        chk("rnd_inst_lat", lat, 16);
        chk("rnd_inst_base", a0, a & ~32'(LB - 1));
        chk("rnd_inst_line", ln, ref_line(a));
      end else if (kind == 1) begin
        run_req(0, 0, a, sz, 0, -1, -1, lat, q, ln, a0, ae);
        chk("rnd_load_lat", lat, nb);
        chk("rnd_load_a", a0, a);
        chk("rnd_load_data", q, ref_load(a, nb));
      end else begin
        for (int i = 0; i < nb; i++) model[ix(a + 32'(i))] = d[8*i +: 8];
        run_req(0, 1, a, sz, d, -1, -1, lat, q, ln, a0, ae);
        chk("rnd_store_lat", lat, nb);
        chk("rnd_store_a", a0, a);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    bad = 0;
    for (int i = 0; i < MSZ; i++) if (ram[i] !== model[i]) bad++;
    chk("ram_image", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
